// File: rtl/if_id_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: bubble encoding, FSM state codes,
// RV32 register-field positions and the IF/ID and skid payload structs.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Instruction-memory handshake: single outstanding request, address held
// stable while req=1 and ready=0; ready marks rdata valid that cycle.
interface if_id_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rdata);
    modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/if_id_fetch_stage_skid.sv
// One-entry {pc, instr} holding buffer for a fetch that completes under stall.
// Latency: loaded entry visible the cycle after load; clear beats load/drain.
// Backpressure: none; the owner only loads when empty.
module fetch_skid_buf
    import if_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       drain_i,
    input  fetch_ent_t load_dat_i,
    output logic       full_o,
    output fetch_ent_t dat_o
);

    logic       full_q;
    fetch_ent_t dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            dat_q  <= load_dat_i;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign dat_o  = dat_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// RV32I fetch stage + IF/ID register; optional perf counters via FETCH_PERF_CNT_EN.
// Latency: a fire on edge N is visible on IF_ID_* after edge N.
// Backpressure: stall freezes IF/ID and PC, parking one fetched word in the skid.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic [31:0]                 branch_target_i,
    if_id_fetch_stage_if.master         imem,
    output logic [31:0]                 IF_ID_pc_o,
    output logic [31:0]                 IF_ID_instr_o,
    output logic                        IF_ID_valid_o,
    output logic [4:0]                  IF_IDrs1_o,
    output logic [4:0]                  IF_IDrs2_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_stall_cycles_o,
    output logic [31:0]                 perf_bubble_cycles_o
`endif
);

    import if_pkg::*;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    if_id_t      if_id_q, if_id_d;
    if_id_t      bubble;
    logic        fire;

    logic        skid_load, skid_drain, skid_clear, skid_full;
    fetch_ent_t  skid_dat;

    // Request drops combinationally in reset so nothing issues before release.
    assign imem.req  = !rst_i && (state_q != ST_HOLD);
    assign imem.addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign fire      = imem.req && imem.ready;

    assign bubble = '{pc: if_id_q.pc, instr: NOP_INSTR, valid: 1'b0};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        if_id_d      = if_id_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;
        if (flush_i) begin
            if_id_d    = bubble;
            skid_clear = 1'b1;
            pc_d       = branch_target_i;
            // An unanswered request must finish at its original address.
            if (imem.req && !fire) begin
                state_d      = ST_DRAIN;
                drain_addr_d = imem.addr;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (fire) begin
                        pc_d = pc_q + 32'd4;
                        if (stall_i) begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end else begin
                            if_id_d = '{pc: pc_q, instr: imem.rdata, valid: 1'b1};
                        end
                    end else if (!stall_i) begin
                        if_id_d = bubble;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        if_id_d    = '{pc: skid_dat.pc, instr: skid_dat.instr, valid: 1'b1};
                        skid_drain = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if_id_d = bubble;
                    if (fire) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            if_id_q      <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            if_id_q      <= if_id_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (skid_clear),
        .load_i     (skid_load),
        .drain_i    (skid_drain),
        .load_dat_i ('{pc: pc_q, instr: imem.rdata}),
        .full_o     (skid_full),
        .dat_o      (skid_dat)
    );

    assign IF_ID_pc_o    = if_id_q.pc;
    assign IF_ID_instr_o = if_id_q.instr;
    assign IF_ID_valid_o = if_id_q.valid;
    assign IF_IDrs1_o    = rs1_of(if_id_q.instr);
    assign IF_IDrs2_o    = rs2_of(if_id_q.instr);

`ifdef FETCH_PERF_CNT_EN
    logic        bubble_load;
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    assign bubble_load = flush_i || (state_q == ST_DRAIN) ||
                         ((state_q == ST_FETCH) && !fire && !stall_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (stall_i && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bubble_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles_o  = stall_cnt_q;
    assign perf_bubble_cycles_o = bubble_cnt_q;
`endif

endmodule
